rgmii_delay_tuner: RTL and testbench

RGMII_DELAY_TUNER -- requirements
Module: rgmii_delay_tuner

---
 rtl/rgmii_delay_pkg.sv | 37 +++
 rtl/rgmii_delay_regs.sv | 111 +++++++++++
 rtl/rgmii_delay_tuner.sv | 204 ++++++++++++++++++++
 tb/tb_rgmii_delay_tuner.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/rgmii_delay_pkg.sv
// Shared register map, control/status bit positions and FSM encodings
// for the RGMII delay tuner.
package rgmii_delay_pkg;
   localparam int ADDR_W = 8;

   localparam logic [ADDR_W-1:0] REG_CTRL     = 8'h00;
   localparam logic [ADDR_W-1:0] REG_STATUS   = 8'h04;
   localparam logic [ADDR_W-1:0] REG_WINDOW   = 8'h08;
   localparam logic [ADDR_W-1:0] REG_TAP_BASE = 8'h10;

   localparam int CTRL_APPLY       = 0;
   localparam int CTRL_SWEEP_START = 1;
   localparam int CTRL_SWEEP_ABORT = 2;
   localparam int CTRL_IRQ_CLEAR   = 3;

   localparam int STATUS_BUSY    = 0;
   localparam int STATUS_DLY_RDY = 1;
   localparam int STATUS_DONE    = 2;
   localparam int STATUS_FAIL    = 3;

   typedef enum logic [2:0] {
      eIdle,
      eLoad,
      eSettle,
      eSample,
      eCenter
   } state_e;

   // What the FSM does once the pending load in eLoad completes.
   typedef enum logic [2:0] {
      eModeApply,
      eModeSweep,
      eModeCenter,
      eModeFail,
      eModeAbort
   } mode_e;
endpackage

// File: rtl/rgmii_delay_regs.sv
// MMIO decode and tap register file; the sweep FSM can overwrite all taps
// at once through tap_set, which takes priority over bus writes.
module rgmii_delay_regs
   import rgmii_delay_pkg::*;
#(
   parameter int data_width_p = 32,
   parameter int lanes_p      = 5,
   parameter int tap_width_p  = 5
)(
   input  logic                           clk,
   input  logic                           reset,
   input  logic [ADDR_W-1:0]              addr,
   input  logic                           write_en,
   input  logic                           read_en,
   input  logic [data_width_p/8-1:0]      write_mask,
   input  logic [data_width_p-1:0]        write_data,
   output logic [data_width_p-1:0]        read_data,
   input  logic                           busy,
   input  logic                           dly_rdy,
   input  logic                           sweep_done,
   input  logic                           sweep_fail,
   input  logic [tap_width_p-1:0]         first,
   input  logic [tap_width_p-1:0]         last,
   input  logic                           tap_set,
   input  logic [lanes_p*tap_width_p-1:0] tap_set_val,
   output logic [lanes_p*tap_width_p-1:0] tap,
   output logic                           apply,
   output logic                           sweep_start,
   output logic                           sweep_abort,
   output logic                           irq_clear
);
   logic [lanes_p-1:0][tap_width_p-1:0] taps;
   logic [ADDR_W-1:0]                   tap_off;
   int                                  tap_idx;
   logic                                tap_hit;
   logic                                tap_wr;
   logic                                ctrl_wr;
   logic [data_width_p-1:0]             bit_en;
   logic [tap_width_p-1:0]              wr_bits;
   logic [tap_width_p-1:0]              wr_en_bits;
   logic [tap_width_p-1:0]              rd_tap;
   logic [data_width_p-1:0]             rd_word;
   logic                                unused;

   assign tap_off = addr - REG_TAP_BASE;
   assign tap_idx = int'(tap_off[ADDR_W-1:2]);
   assign tap_hit = (addr >= REG_TAP_BASE) && (tap_off[1:0] == 2'b00) && (tap_idx < lanes_p);
   assign tap_wr  = write_en && tap_hit && !busy;

   assign ctrl_wr     = write_en && (addr == REG_CTRL) && write_mask[0];
   assign apply       = ctrl_wr && write_data[CTRL_APPLY];
   assign sweep_start = ctrl_wr && write_data[CTRL_SWEEP_START];
   assign sweep_abort = ctrl_wr && write_data[CTRL_SWEEP_ABORT];
   assign irq_clear   = ctrl_wr && write_data[CTRL_IRQ_CLEAR];

   // Expand byte enables to bit enables so partial-mask writes merge cleanly.
   always_comb begin
      bit_en = '0;
      for (int b = 0; b < data_width_p/8; b++)
         bit_en[b*8 +: 8] = {8{write_mask[b]}};
   end

   assign wr_en_bits = bit_en[tap_width_p-1:0];
   assign wr_bits    = write_data[tap_width_p-1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         taps <= '0;
      end else if (tap_set) begin
         taps <= tap_set_val;
      end else if (tap_wr) begin
         for (int i = 0; i < lanes_p; i++)
            if (tap_idx == i)
               taps[i] <= (taps[i] & ~wr_en_bits) | (wr_bits & wr_en_bits);
      end
   end

   assign tap = taps;

   always_comb begin
      rd_tap = '0;
      for (int i = 0; i < lanes_p; i++)
         if (tap_idx == i) rd_tap = taps[i];
   end

   always_comb begin
      rd_word = '0;
      case (addr)
         REG_STATUS: begin
            rd_word[STATUS_BUSY]    = busy;
            rd_word[STATUS_DLY_RDY] = dly_rdy;
            rd_word[STATUS_DONE]    = sweep_done;
            rd_word[STATUS_FAIL]    = sweep_fail;
         end
         REG_WINDOW: begin
            rd_word[7:0]  = 8'(first);
            rd_word[15:8] = 8'(last);
         end
         default: begin
            if (tap_hit) rd_word[tap_width_p-1:0] = rd_tap;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset)        read_data <= '0;
      else if (read_en) read_data <= rd_word;
   end

   assign unused = &{1'b0, write_data[data_width_p-1:tap_width_p], bit_en[data_width_p-1:tap_width_p]};
endmodule

// File: rtl/rgmii_delay_tuner.sv
// RGMII input-delay tuner: applies software taps or sweeps all lanes together,
// finds the passing window from pattern_ok_i and centres the taps in it.
module rgmii_delay_tuner
   import rgmii_delay_pkg::*;
#(
   parameter int   data_width_p    = 32,
   parameter int   lanes_p         = 5,
   parameter int   tap_width_p     = 5,
   parameter int   settle_cycles_p = 16,
   localparam int  addr_width_lp   = 8
)(
   input  logic                           clk_i,
   input  logic                           reset_i,
   input  logic [addr_width_lp-1:0]       addr_i,
   input  logic                           write_en_i,
   input  logic                           read_en_i,
   input  logic [data_width_p/8-1:0]      write_mask_i,
   input  logic [data_width_p-1:0]        write_data_i,
   output logic [data_width_p-1:0]        read_data_o,
   input  logic                           dly_rdy_i,
   input  logic                           pattern_ok_i,
   output logic [lanes_p*tap_width_p-1:0] tap_o,
   output logic [lanes_p-1:0]             tap_load_o,
   output logic                           done_interrupt_o
);
   localparam int cnt_w_lp = $clog2(settle_cycles_p + 1);
   localparam logic [cnt_w_lp-1:0] settle_last_lp = cnt_w_lp'(settle_cycles_p - 1);

   state_e                         state;
   mode_e                          mode;
   logic [tap_width_p-1:0]         cur;
   logic [tap_width_p-1:0]         next_tap;
   logic [tap_width_p-1:0]         first;
   logic [tap_width_p-1:0]         last;
   logic [tap_width_p-1:0]         center;
   logic [tap_width_p:0]           sum;
   logic                           found;
   logic [cnt_w_lp-1:0]            settle_cnt;
   logic [lanes_p*tap_width_p-1:0] saved;
   logic                           sweep_done;
   logic                           sweep_fail;
   logic                           busy;
   logic                           sample_end;
   logic                           tap_set;
   logic [lanes_p*tap_width_p-1:0] tap_set_val;
   logic                           apply;
   logic                           sweep_start;
   logic                           sweep_abort;
   logic                           irq_clear;
   logic                           unused;

   rgmii_delay_regs #(
      .data_width_p (data_width_p),
      .lanes_p      (lanes_p),
      .tap_width_p  (tap_width_p)
   ) u_regs (
      .clk         (clk_i),
      .reset       (reset_i),
      .addr        (addr_i),
      .write_en    (write_en_i),
      .read_en     (read_en_i),
      .write_mask  (write_mask_i),
      .write_data  (write_data_i),
      .read_data   (read_data_o),
      .busy        (busy),
      .dly_rdy     (dly_rdy_i),
      .sweep_done  (sweep_done),
      .sweep_fail  (sweep_fail),
      .first       (first),
      .last        (last),
      .tap_set     (tap_set),
      .tap_set_val (tap_set_val),
      .tap         (tap_o),
      .apply       (apply),
      .sweep_start (sweep_start),
      .sweep_abort (sweep_abort),
      .irq_clear   (irq_clear)
   );

   assign busy             = (state != eIdle);
   assign done_interrupt_o = sweep_done;
   assign next_tap         = cur + 1'b1;
   assign sum              = {1'b0, first} + {1'b0, last};
   assign center           = sum[tap_width_p:1];
   // Window closes on the first fail after a pass, or when the tap range runs out.
   assign sample_end       = (found && !pattern_ok_i) || (cur == '1);

   // Tap overwrite requests; they land in the register file on the same edge
   // the FSM enters eLoad, so tap_o is settled before the load strobe.
   always_comb begin
      tap_set     = 1'b0;
      tap_set_val = saved;
      if (busy && sweep_abort) begin
         tap_set = 1'b1;
      end else begin
         case (state)
            eIdle: begin
               if (sweep_start) begin
                  tap_set     = 1'b1;
                  tap_set_val = '0;
               end
            end
            eSample: begin
               if (!sample_end) begin
                  tap_set     = 1'b1;
                  tap_set_val = {lanes_p{next_tap}};
               end
            end
            eCenter: begin
               tap_set = 1'b1;
               if (found) tap_set_val = {lanes_p{center}};
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state      <= eIdle;
         mode       <= eModeApply;
         cur        <= '0;
         first      <= '0;
         last       <= '0;
         found      <= 1'b0;
         settle_cnt <= '0;
         saved      <= '0;
         sweep_done <= 1'b0;
         sweep_fail <= 1'b0;
         tap_load_o <= '0;
      end else begin
         tap_load_o <= '0;
         // Later assignments in this block override the clear, so a set wins.
         if (irq_clear) begin
            sweep_done <= 1'b0;
            sweep_fail <= 1'b0;
         end
         if (busy && sweep_abort) begin
            mode  <= eModeAbort;
            state <= eLoad;
         end else begin
            case (state)
               eIdle: begin
                  if (sweep_start) begin
                     saved <= tap_o;
                     cur   <= '0;
                     first <= '0;
                     last  <= '0;
                     found <= 1'b0;
                     mode  <= eModeSweep;
                     state <= eLoad;
                  end else if (apply) begin
                     saved <= tap_o;
                     mode  <= eModeApply;
                     state <= eLoad;
                  end
               end
               eLoad: begin
                  if (dly_rdy_i) begin
                     tap_load_o <= '1;
                     state      <= eIdle;
                     case (mode)
                        eModeSweep: begin
                           settle_cnt <= '0;
                           state      <= eSettle;
                        end
                        eModeCenter: sweep_done <= 1'b1;
                        eModeFail: begin
                           sweep_done <= 1'b1;
                           sweep_fail <= 1'b1;
                        end
                        default: ;
                     endcase
                  end
               end
               eSettle: begin
                  if (settle_cnt == settle_last_lp) state <= eSample;
                  else settle_cnt <= settle_cnt + 1'b1;
               end
               eSample: begin
                  if (pattern_ok_i) begin
                     if (!found) first <= cur;
                     last  <= cur;
                     found <= 1'b1;
                  end
                  if (sample_end) begin
                     state <= eCenter;
                  end else begin
                     cur   <= next_tap;
                     state <= eLoad;
                  end
               end
               eCenter: begin
                  mode  <= found ? eModeCenter : eModeFail;
                  state <= eLoad;
               end
               default: state <= eIdle;
            endcase
         end
      end
   end

   assign unused = &{1'b0, sum[0]};
endmodule

// File: tb/tb_rgmii_delay_tuner.sv
// Directed bench for rgmii_delay_tuner: apply, masked writes, pass/fail/abort
// sweeps and reset mid-sweep, checked against hand-computed values.
module tb_rgmii_delay_tuner;
   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  addr;
   logic        write_en;
   logic        read_en;
   logic [3:0]  mask;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        dly_rdy;
   logic        pattern_ok;
   logic [24:0] tap;
   logic [4:0]  tap_load;
   logic        irq;

   int          checks = 0;
   int          errors = 0;
   int          full_pulses = 0;
   int          part_pulses = 0;
   logic [24:0] pulse_tap = '0;
   int          pat_mode = 0;
   logic [31:0] rd;

   always #5 clk = ~clk;

   rgmii_delay_tuner dut (
      .clk_i            (clk),
      .reset_i          (reset),
      .addr_i           (addr),
      .write_en_i       (write_en),
      .read_en_i        (read_en),
      .write_mask_i     (mask),
      .write_data_i     (wdata),
      .read_data_o      (rdata),
      .dly_rdy_i        (dly_rdy),
      .pattern_ok_i     (pattern_ok),
      .tap_o            (tap),
      .tap_load_o       (tap_load),
      .done_interrupt_o (irq)
   );

   // Link partner model: pattern passes only for taps 6..14 in mode 1.
   assign pattern_ok = (pat_mode == 1) && (tap[4:0] >= 5'd6) && (tap[4:0] <= 5'd14);

   always @(posedge clk) begin
      if (tap_load != '0) begin
         if (tap_load == 5'h1f) full_pulses++;
         else part_pulses++;
         pulse_tap = tap;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m);
      addr = a; wdata = d; mask = m; write_en = 1'b1;
      tick(1);
      write_en = 1'b0; mask = '0;
   endtask

   task automatic rdr(input logic [7:0] a, output logic [31:0] d);
      addr = a; read_en = 1'b1;
      tick(1);
      read_en = 1'b0;
      d = rdata;
   endtask

   task automatic wait_idle(input string tag);
      logic [31:0] s;
      int n = 0;
      do begin
         rdr(8'h04, s);
         n++;
      end while (s[0] && n < 500);
      chk(tag, {31'd0, s[0]}, 32'd0);
   endtask

   task automatic wait_irq(input string tag);
      int n = 0;
      while (!irq && n < 2000) begin
         tick(1);
         n++;
      end
      chk(tag, {31'd0, irq}, 32'd1);
   endtask

   function automatic logic [24:0] rep(input logic [4:0] v);
      return {5{v}};
   endfunction

   initial begin
      reset = 1'b1; write_en = 1'b0; read_en = 1'b0; addr = '0;
      wdata = '0; mask = '0; dly_rdy = 1'b1;
      tick(3);
      chk("rst_tap_load", {27'd0, tap_load}, 32'd0);
      chk("rst_read_data", rdata, 32'd0);
      chk("rst_irq", {31'd0, irq}, 32'd0);
      chk("rst_tap", {7'd0, tap}, 32'd0);
      reset = 1'b0;
      rdr(8'h04, rd); chk("rst_status", rd, 32'h2);
      rdr(8'h10, rd); chk("rst_tap0", rd, 32'd0);

      // apply with controller ready
      wr(8'h18, 32'd9, 4'hf);
      full_pulses = 0; part_pulses = 0;
      wr(8'h00, 32'h1, 4'h1);
      wait_idle("apply_idle");
      chk("apply_pulses", full_pulses, 1);
      chk("apply_partial", part_pulses, 0);
      chk("apply_pulse_lane2", {27'd0, pulse_tap[14:10]}, 32'd9);
      chk("apply_tap_o", {7'd0, tap}, 32'h2400);
      rdr(8'h18, rd); chk("tap2_read", rd, 32'd9);

      // apply held off by dly_rdy
      full_pulses = 0; part_pulses = 0;
      dly_rdy = 1'b0;
      wr(8'h00, 32'h1, 4'h1);
      tick(10);
      chk("hold_pulses", full_pulses + part_pulses, 0);
      rdr(8'h04, rd); chk("hold_status", rd, 32'h1);
      dly_rdy = 1'b1;
      wait_idle("rdy_idle");
      chk("rdy_pulses", full_pulses, 1);

      // byte masks, read hold, unmapped read
      wr(8'h10, 32'h1f, 4'h0);
      wr(8'h14, 32'h15, 4'h2);
      rdr(8'h10, rd); chk("mask0_tap0", rd, 32'd0);
      rdr(8'h14, rd); chk("mask2_tap1", rd, 32'd0);
      wr(8'h14, 32'h15, 4'h1);
      rdr(8'h14, rd); chk("mask1_tap1", rd, 32'h15);
      tick(2);
      chk("read_hold", rdata, 32'h15);
      rdr(8'h3c, rd); chk("unmapped_read", rd, 32'd0);
      chk("taps_after_mask", {7'd0, tap}, 32'h26a0);

      // sweep with passing window 6..14
      pat_mode = 1; full_pulses = 0; part_pulses = 0;
      wr(8'h00, 32'h2, 4'h1);
      wait_irq("pass_irq");
      wait_idle("pass_idle");
      rdr(8'h08, rd); chk("pass_window", rd, 32'h0e06);
      chk("pass_center", {7'd0, tap}, {7'd0, rep(5'd10)});
      rdr(8'h04, rd); chk("pass_status", rd, 32'h6);
      chk("pass_irq_level", {31'd0, irq}, 32'd1);
      chk("pass_pulses", full_pulses, 17);
      wr(8'h00, 32'h8, 4'h1);
      chk("irq_cleared", {31'd0, irq}, 32'd0);

      // sweep that never passes; writes during it are ignored
      pat_mode = 0; full_pulses = 0; part_pulses = 0;
      wr(8'h00, 32'h2, 4'h1);
      tick(5);
      wr(8'h10, 32'd7, 4'hf);
      wr(8'h00, 32'h1, 4'h1);
      wait_irq("fail_irq");
      wait_idle("fail_idle");
      chk("fail_pulses", full_pulses, 33);
      rdr(8'h04, rd); chk("fail_status", rd, 32'he);
      chk("fail_restore", {7'd0, tap}, {7'd0, rep(5'd10)});
      rdr(8'h10, rd); chk("busy_write_ignored", rd, 32'd10);
      rdr(8'h08, rd); chk("fail_window", rd, 32'd0);
      wr(8'h00, 32'h8, 4'h1);
      rdr(8'h04, rd); chk("fail_cleared", rd, 32'h2);

      // abort at tap 4
      wr(8'h10, 32'd3, 4'hf);
      wr(8'h20, 32'd17, 4'hf);
      pat_mode = 1; full_pulses = 0; part_pulses = 0;
      wr(8'h00, 32'h2, 4'h1);
      begin
         int n = 0;
         while (tap[4:0] != 5'd4 && n < 500) begin
            tick(1);
            n++;
         end
      end
      chk("abort_reach_tap4", {27'd0, tap[4:0]}, 32'd4);
      tick(3);
      wr(8'h00, 32'h4, 4'h1);
      wait_idle("abort_idle");
      chk("abort_restore", {7'd0, tap}, {7'd0, 5'd17, 5'd10, 5'd10, 5'd10, 5'd3});
      chk("abort_irq", {31'd0, irq}, 32'd0);
      rdr(8'h04, rd); chk("abort_status", rd, 32'h2);
      chk("abort_pulses", full_pulses, 6);

      // reset mid-sweep
      wr(8'h00, 32'h2, 4'h1);
      tick(30);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      full_pulses = 0; part_pulses = 0;
      tick(40);
      chk("midrst_pulses", full_pulses + part_pulses, 0);
      chk("midrst_irq", {31'd0, irq}, 32'd0);
      chk("midrst_tap", {7'd0, tap}, 32'd0);
      rdr(8'h04, rd); chk("midrst_status", rd, 32'h2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
